// File: rtl/vend_sequencer.sv
`default_nettype none
// =============================================================================
// Module      : vend_sequencer
// Description : Vending controller in front of a nickel-unit coin counter.
//               Credits or rejects coins, deducts the selected price with
//               greedy 25c/10c/5c counter decrements, pulses dispense and
//               then pays out change one coin per cycle. Sole driver of the
//               counter's increment and decrement strobes.
// Revision    : 1.0 - initial release
// =============================================================================
module vend_sequencer #(
    parameter int CW          = 6,
    parameter bit AUTO_CHANGE = 1'b1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          nickel,
    input  logic          dime,
    input  logic          quarter,
    input  logic          dollar,
    input  logic          sel_valid,
    input  logic [CW-1:0] sel_price,
    input  logic          cancel,
    input  logic [CW-1:0] coin_count,
    output logic          cnt_nickel,
    output logic          cnt_dime,
    output logic          cnt_quarter,
    output logic          cnt_dollar,
    output logic          cnt_down_5,
    output logic          cnt_down_10,
    output logic          cnt_down_25,
    output logic          eject_5,
    output logic          eject_10,
    output logic          eject_25,
    output logic          coin_reject,
    output logic          sel_denied,
    output logic          dispense,
    output logic          busy
);

    // Credit values carry one guard bit so a coin on top of full credit
    // can be compared against the maximum without wrapping.
    typedef logic [CW:0]   credit_t;
    typedef logic [CW-1:0] rem_t;

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_DEDUCT   = 2'd1,
        S_DISPENSE = 2'd2,
        S_CHANGE   = 2'd3
    } state_t;

    localparam credit_t c_max_credit = credit_t'((1 << CW) - 1);
    localparam credit_t c_val_1      = credit_t'(1);
    localparam credit_t c_val_2      = credit_t'(2);
    localparam credit_t c_val_5      = credit_t'(5);
    localparam credit_t c_val_20     = credit_t'(20);
    localparam rem_t    c_rem_1      = rem_t'(1);
    localparam rem_t    c_rem_2      = rem_t'(2);
    localparam rem_t    c_rem_5      = rem_t'(5);

    // ------------------------------------------------------------------
    // Registered state and outputs
    // ------------------------------------------------------------------
    state_t  r_state;
    rem_t    r_rem;
    logic    r_cnt_nickel;
    logic    r_cnt_dime;
    logic    r_cnt_quarter;
    logic    r_cnt_dollar;
    logic    r_cnt_down_5;
    logic    r_cnt_down_10;
    logic    r_cnt_down_25;
    logic    r_eject_5;
    logic    r_eject_10;
    logic    r_eject_25;
    logic    r_coin_reject;
    logic    r_sel_denied;
    logic    r_dispense;
    logic    r_busy;

    // ------------------------------------------------------------------
    // Combinational helpers and next values
    // ------------------------------------------------------------------
    credit_t w_credit_up;
    credit_t w_credit_dn;
    credit_t w_credit_eff;
    logic    w_coin_any;
    logic    w_coin_multi;
    credit_t w_coin_val;
    logic    w_coin_fits;
    rem_t    w_ded_step;
    credit_t w_chg_step;
    state_t  w_state_next;
    rem_t    w_rem_next;
    logic    w_cnt_nickel;
    logic    w_cnt_dime;
    logic    w_cnt_quarter;
    logic    w_cnt_dollar;
    logic    w_cnt_down_5;
    logic    w_cnt_down_10;
    logic    w_cnt_down_25;
    logic    w_eject_5;
    logic    w_eject_10;
    logic    w_eject_25;
    logic    w_coin_reject;
    logic    w_sel_denied;
    logic    w_dispense;

    // Effective credit: the counter readback lags our strobe by one cycle,
    // so add the delta of the strobe that is currently being applied.
    always_comb begin
        w_credit_up = '0;
        if (r_cnt_dollar) begin
            w_credit_up = c_val_20;
        end else if (r_cnt_quarter) begin
            w_credit_up = c_val_5;
        end else if (r_cnt_dime) begin
            w_credit_up = c_val_2;
        end else if (r_cnt_nickel) begin
            w_credit_up = c_val_1;
        end
        w_credit_dn = '0;
        if (r_cnt_down_25) begin
            w_credit_dn = c_val_5;
        end else if (r_cnt_down_10) begin
            w_credit_dn = c_val_2;
        end else if (r_cnt_down_5) begin
            w_credit_dn = c_val_1;
        end
        w_credit_eff = {1'b0, coin_count} + w_credit_up - w_credit_dn;
    end

    // Coin decode: only the highest-valued pulse of a cycle is a candidate.
    always_comb begin
        w_coin_any   = nickel | dime | quarter | dollar;
        w_coin_multi = (nickel & (dime | quarter | dollar)) |
                       (dime & (quarter | dollar)) |
                       (quarter & dollar);
        w_coin_val   = '0;
        if (dollar) begin
            w_coin_val = c_val_20;
        end else if (quarter) begin
            w_coin_val = c_val_5;
        end else if (dime) begin
            w_coin_val = c_val_2;
        end else if (nickel) begin
            w_coin_val = c_val_1;
        end
        w_coin_fits = (w_credit_eff + w_coin_val) <= c_max_credit;
    end

    // Greedy step sizes for price deduction and change payout.
    always_comb begin
        w_ded_step = '0;
        if (r_rem >= c_rem_5) begin
            w_ded_step = c_rem_5;
        end else if (r_rem >= c_rem_2) begin
            w_ded_step = c_rem_2;
        end else if (r_rem >= c_rem_1) begin
            w_ded_step = c_rem_1;
        end
        w_chg_step = '0;
        if (w_credit_eff >= c_val_5) begin
            w_chg_step = c_val_5;
        end else if (w_credit_eff >= c_val_2) begin
            w_chg_step = c_val_2;
        end else if (w_credit_eff >= c_val_1) begin
            w_chg_step = c_val_1;
        end
    end

    // Next-state and next-output decisions.
    always_comb begin
        w_state_next  = r_state;
        w_rem_next    = r_rem;
        w_cnt_nickel  = 1'b0;
        w_cnt_dime    = 1'b0;
        w_cnt_quarter = 1'b0;
        w_cnt_dollar  = 1'b0;
        w_cnt_down_5  = 1'b0;
        w_cnt_down_10 = 1'b0;
        w_cnt_down_25 = 1'b0;
        w_eject_5     = 1'b0;
        w_eject_10    = 1'b0;
        w_eject_25    = 1'b0;
        w_coin_reject = 1'b0;
        w_sel_denied  = 1'b0;
        w_dispense    = 1'b0;

        // Outside IDLE every coin goes back and every request is refused.
        if (r_state != S_IDLE) begin
            w_coin_reject = w_coin_any;
            w_sel_denied  = sel_valid;
        end

        case (r_state)
            S_IDLE: begin
                if (sel_valid) begin
                    w_coin_reject = w_coin_any;
                    if ((sel_price == '0) || ({1'b0, sel_price} > w_credit_eff)) begin
                        w_sel_denied = 1'b1;
                    end else begin
                        w_rem_next   = sel_price;
                        w_state_next = S_DEDUCT;
                    end
                end else if (cancel) begin
                    w_coin_reject = w_coin_any;
                    if (w_credit_eff != '0) begin
                        w_state_next = S_CHANGE;
                    end
                end else if (w_coin_any) begin
                    // Lower-valued companions of the chosen coin are returned.
                    w_coin_reject = w_coin_multi;
                    if (w_coin_fits) begin
                        w_cnt_dollar  = dollar;
                        w_cnt_quarter = quarter & ~dollar;
                        w_cnt_dime    = dime & ~quarter & ~dollar;
                        w_cnt_nickel  = nickel & ~dime & ~quarter & ~dollar;
                    end else begin
                        w_coin_reject = 1'b1;
                    end
                end
            end
            S_DEDUCT: begin
                w_cnt_down_25 = (w_ded_step == c_rem_5);
                w_cnt_down_10 = (w_ded_step == c_rem_2);
                w_cnt_down_5  = (w_ded_step == c_rem_1);
                w_rem_next    = r_rem - w_ded_step;
                if (w_rem_next == '0) begin
                    w_state_next = S_DISPENSE;
                end
            end
            S_DISPENSE: begin
                w_dispense = 1'b1;
                if (AUTO_CHANGE && (w_credit_eff != '0)) begin
                    w_state_next = S_CHANGE;
                end else begin
                    w_state_next = S_IDLE;
                end
            end
            S_CHANGE: begin
                w_cnt_down_25 = (w_chg_step == c_val_5);
                w_cnt_down_10 = (w_chg_step == c_val_2);
                w_cnt_down_5  = (w_chg_step == c_val_1);
                w_eject_25    = w_cnt_down_25;
                w_eject_10    = w_cnt_down_10;
                w_eject_5     = w_cnt_down_5;
                // Leave as soon as the coin being paid empties the credit.
                if (w_credit_eff == w_chg_step) begin
                    w_state_next = S_IDLE;
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // State and remaining-price register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_rem   <= '0;
        end else begin
            r_state <= w_state_next;
            r_rem   <= w_rem_next;
        end
    end

    // Output register; busy tracks the state it is registered alongside.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt_nickel  <= 1'b0;
            r_cnt_dime    <= 1'b0;
            r_cnt_quarter <= 1'b0;
            r_cnt_dollar  <= 1'b0;
            r_cnt_down_5  <= 1'b0;
            r_cnt_down_10 <= 1'b0;
            r_cnt_down_25 <= 1'b0;
            r_eject_5     <= 1'b0;
            r_eject_10    <= 1'b0;
            r_eject_25    <= 1'b0;
            r_coin_reject <= 1'b0;
            r_sel_denied  <= 1'b0;
            r_dispense    <= 1'b0;
            r_busy        <= 1'b0;
        end else begin
            r_cnt_nickel  <= w_cnt_nickel;
            r_cnt_dime    <= w_cnt_dime;
            r_cnt_quarter <= w_cnt_quarter;
            r_cnt_dollar  <= w_cnt_dollar;
            r_cnt_down_5  <= w_cnt_down_5;
            r_cnt_down_10 <= w_cnt_down_10;
            r_cnt_down_25 <= w_cnt_down_25;
            r_eject_5     <= w_eject_5;
            r_eject_10    <= w_eject_10;
            r_eject_25    <= w_eject_25;
            r_coin_reject <= w_coin_reject;
            r_sel_denied  <= w_sel_denied;
            r_dispense    <= w_dispense;
            r_busy        <= (w_state_next != S_IDLE);
        end
    end

    assign cnt_nickel  = r_cnt_nickel;
    assign cnt_dime    = r_cnt_dime;
    assign cnt_quarter = r_cnt_quarter;
    assign cnt_dollar  = r_cnt_dollar;
    assign cnt_down_5  = r_cnt_down_5;
    assign cnt_down_10 = r_cnt_down_10;
    assign cnt_down_25 = r_cnt_down_25;
    assign eject_5     = r_eject_5;
    assign eject_10    = r_eject_10;
    assign eject_25    = r_eject_25;
    assign coin_reject = r_coin_reject;
    assign sel_denied  = r_sel_denied;
    assign dispense    = r_dispense;
    assign busy        = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_vend_sequencer.sv
`default_nettype none
// =============================================================================
// Module      : tb_vend_sequencer
// Description : Self-checking bench for vend_sequencer with a model of the
//               external coin counter, a directed vector table, hand-written
//               multi-cycle sequences and a randomized phase against a
//               plan-queue reference model.
// Revision    : 1.0 - initial release
// =============================================================================
module tb_vend_sequencer;

    localparam int B_NICKEL = 13, B_DIME = 12, B_QUARTER = 11, B_DOLLAR = 10;
    localparam int B_D25 = 9, B_D10 = 8, B_D5 = 7, B_E25 = 6, B_E10 = 5, B_E5 = 4;
    localparam int B_REJ = 3, B_DEN = 2, B_DISP = 1, B_BUSY = 0;

    localparam logic [13:0] O_NONE    = 14'd0;
    localparam logic [13:0] O_NICKEL  = 14'd1 << B_NICKEL;
    localparam logic [13:0] O_DIME    = 14'd1 << B_DIME;
    localparam logic [13:0] O_QUARTER = 14'd1 << B_QUARTER;
    localparam logic [13:0] O_DOLLAR  = 14'd1 << B_DOLLAR;
    localparam logic [13:0] O_D25     = 14'd1 << B_D25;
    localparam logic [13:0] O_D10     = 14'd1 << B_D10;
    localparam logic [13:0] O_D5      = 14'd1 << B_D5;
    localparam logic [13:0] O_E25     = 14'd1 << B_E25;
    localparam logic [13:0] O_E10     = 14'd1 << B_E10;
    localparam logic [13:0] O_E5      = 14'd1 << B_E5;
    localparam logic [13:0] O_REJ     = 14'd1 << B_REJ;
    localparam logic [13:0] O_DEN     = 14'd1 << B_DEN;
    localparam logic [13:0] O_DISP    = 14'd1 << B_DISP;
    localparam logic [13:0] O_BUSY    = 14'd1 << B_BUSY;

    // coin input nibble order: {dollar, quarter, dime, nickel}
    localparam logic [3:0] C_0 = 4'b0000, C_N = 4'b0001, C_D = 4'b0010;
    localparam logic [3:0] C_Q = 4'b0100, C_DL = 4'b1000;

    logic       clk, reset;
    logic       nickel, dime, quarter, dollar, sel_valid, cancel;
    logic [5:0] sel_price, coin_count;
    logic       cnt_nickel, cnt_dime, cnt_quarter, cnt_dollar;
    logic       cnt_down_5, cnt_down_10, cnt_down_25;
    logic       eject_5, eject_10, eject_25;
    logic       coin_reject, sel_denied, dispense, busy;
    logic [13:0] dut_vec;

    int n_checks = 0;
    int n_pass   = 0;

    vend_sequencer #(.CW(6), .AUTO_CHANGE(1'b1)) dut (
        .clk(clk), .reset(reset),
        .nickel(nickel), .dime(dime), .quarter(quarter), .dollar(dollar),
        .sel_valid(sel_valid), .sel_price(sel_price), .cancel(cancel),
        .coin_count(coin_count),
        .cnt_nickel(cnt_nickel), .cnt_dime(cnt_dime),
        .cnt_quarter(cnt_quarter), .cnt_dollar(cnt_dollar),
        .cnt_down_5(cnt_down_5), .cnt_down_10(cnt_down_10), .cnt_down_25(cnt_down_25),
        .eject_5(eject_5), .eject_10(eject_10), .eject_25(eject_25),
        .coin_reject(coin_reject), .sel_denied(sel_denied),
        .dispense(dispense), .busy(busy)
    );

    assign dut_vec = {cnt_nickel, cnt_dime, cnt_quarter, cnt_dollar,
                      cnt_down_25, cnt_down_10, cnt_down_5,
                      eject_25, eject_10, eject_5,
                      coin_reject, sel_denied, dispense, busy};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Signed credit change carried by a set of counter strobes.
    function automatic int vec_delta(input logic [13:0] v);
        int d;
        d = 0;
        if (v[B_NICKEL])  d += 1;
        if (v[B_DIME])    d += 2;
        if (v[B_QUARTER]) d += 5;
        if (v[B_DOLLAR])  d += 20;
        if (v[B_D25])     d -= 5;
        if (v[B_D10])     d -= 2;
        if (v[B_D5])      d -= 1;
        return d;
    endfunction

    // External 6-bit coin counter driven by the DUT strobes.
    always @(posedge clk or posedge reset) begin
        if (reset) coin_count <= '0;
        else       coin_count <= 6'(int'(coin_count) + vec_delta(dut_vec));
    end

    // ---------------- reference model: credit plus a queue of planned cycles
    int          m_credit;
    int          m_credit_before;
    logic [13:0] m_plan[$];
    logic [13:0] m_exp;

    task automatic model_reset();
        m_credit = 0;
        m_credit_before = 0;
        m_plan.delete();
        m_exp = O_NONE;
    endtask

    task automatic plan_change(input int amount);
        int a;
        a = amount;
        while (a > 0) begin
            if (a >= 5)      begin m_plan.push_back(O_D25 | O_E25); a -= 5; end
            else if (a >= 2) begin m_plan.push_back(O_D10 | O_E10); a -= 2; end
            else             begin m_plan.push_back(O_D5 | O_E5);   a -= 1; end
        end
    endtask

    task automatic plan_vend(input int price);
        int r;
        r = price;
        while (r > 0) begin
            if (r >= 5)      begin m_plan.push_back(O_D25); r -= 5; end
            else if (r >= 2) begin m_plan.push_back(O_D10); r -= 2; end
            else             begin m_plan.push_back(O_D5);  r -= 1; end
        end
        m_plan.push_back(O_DISP);
        plan_change(m_credit - price);
    endtask

    task automatic model_edge();
        logic [13:0] e;
        int          ncoin, v;
        ncoin = $countones({dollar, quarter, dime, nickel});
        e = O_NONE;
        m_credit_before = m_credit;
        if (m_plan.size() > 0) begin
            e = m_plan.pop_front();
            if (ncoin > 0) e |= O_REJ;
            if (sel_valid) e |= O_DEN;
        end else if (sel_valid) begin
            if (ncoin > 0) e |= O_REJ;
            if (sel_price == 6'd0 || int'(sel_price) > m_credit) e |= O_DEN;
            else plan_vend(int'(sel_price));
        end else if (cancel) begin
            if (ncoin > 0) e |= O_REJ;
            if (m_credit > 0) plan_change(m_credit);
        end else if (ncoin > 0) begin
            if (ncoin > 1) e |= O_REJ;
            v = dollar ? 20 : quarter ? 5 : dime ? 2 : 1;
            if (m_credit + v <= 63) begin
                case (v)
                    20:      e |= O_DOLLAR;
                    5:       e |= O_QUARTER;
                    2:       e |= O_DIME;
                    default: e |= O_NICKEL;
                endcase
            end else begin
                e |= O_REJ;
            end
        end
        if (m_plan.size() > 0) e |= O_BUSY;
        m_credit += vec_delta(e);
        m_exp = e;
    endtask

    // ---------------- stimulus and checking helpers
    task automatic check_vec(input string name, input logic [13:0] got, input logic [13:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: outputs %b, required %b", name, got, exp);
    endtask

    task automatic check_int(input string name, input int got, input int exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: value %0d, required %0d", name, got, exp);
    endtask

    task automatic apply(input logic [3:0] coins, input logic sv, input logic [5:0] price,
                         input logic cn);
        {dollar, quarter, dime, nickel} = coins;
        sel_valid = sv;
        sel_price = price;
        cancel    = cn;
        @(posedge clk);
        model_edge();
        @(negedge clk);
        {dollar, quarter, dime, nickel} = 4'b0;
        sel_valid = 1'b0;
        cancel    = 1'b0;
    endtask

    task automatic step(input string name, input logic [3:0] coins, input logic sv,
                        input logic [5:0] price, input logic cn, input logic [13:0] exp);
        apply(coins, sv, price, cn);
        check_vec(name, dut_vec, exp);
    endtask

    typedef struct {
        logic [3:0]  coins;
        logic        sv;
        logic [5:0]  price;
        logic        cn;
        logic [13:0] exp;
        int          cnt;    // expected coin_count after the step, -1 = skip
    } vec_t;

    function automatic vec_t mk(input logic [3:0] c, input logic sv, input logic [5:0] p,
                                input logic cn, input logic [13:0] e, input int cnt);
        vec_t t;
        t.coins = c; t.sv = sv; t.price = p; t.cn = cn; t.exp = e; t.cnt = cnt;
        return t;
    endfunction

    initial begin
        vec_t        tv[$];
        logic [3:0]  c;
        logic        s;
        logic [13:0] e;
        int          bcnt;

        reset = 1'b1;
        {dollar, quarter, dime, nickel} = 4'b0;
        sel_valid = 1'b0; sel_price = '0; cancel = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_vec("reset_outputs", dut_vec, O_NONE);
        check_int("reset_count", int'(coin_count), 0);
        reset = 1'b0;

        // ---- table: coin acceptance, overflow boundary, trivial denials
        tv.push_back(mk(C_Q,  0, 0, 0, O_QUARTER, -1));
        tv.push_back(mk(C_0,  0, 0, 0, O_NONE,    -1));
        tv.push_back(mk(C_0,  0, 0, 0, O_NONE,    -1));
        tv.push_back(mk(C_D,  0, 0, 0, O_DIME,    -1));
        tv.push_back(mk(C_0,  0, 0, 0, O_NONE,    -1));
        tv.push_back(mk(C_0,  0, 0, 0, O_NONE,    -1));
        tv.push_back(mk(C_N,  0, 0, 0, O_NICKEL,  -1));
        tv.push_back(mk(C_0,  0, 0, 0, O_NONE,     8));
        tv.push_back(mk(C_DL, 0, 0, 0, O_DOLLAR,  -1));
        tv.push_back(mk(C_DL, 0, 0, 0, O_DOLLAR,  -1));
        tv.push_back(mk(C_Q,  0, 0, 0, O_QUARTER, -1));
        tv.push_back(mk(C_Q,  0, 0, 0, O_QUARTER, -1));
        tv.push_back(mk(C_D,  0, 0, 0, O_DIME,    -1));
        tv.push_back(mk(C_Q,  0, 0, 0, O_REJ,     -1));
        tv.push_back(mk(C_N,  0, 0, 0, O_NICKEL,  -1));
        tv.push_back(mk(C_0,  0, 0, 0, O_NONE,    61));
        tv.push_back(mk(C_D,  0, 0, 0, O_DIME,    -1));
        tv.push_back(mk(C_N,  0, 0, 0, O_REJ,     -1));
        tv.push_back(mk(C_0,  0, 0, 0, O_NONE,    63));
        tv.push_back(mk(C_0,  1, 0, 0, O_DEN,     -1));
        tv.push_back(mk(C_Q,  1, 0, 0, O_DEN | O_REJ, -1));
        tv.push_back(mk(C_N | C_DL, 0, 0, 0, O_REJ, -1));
        tv.push_back(mk(C_0,  0, 0, 0, O_NONE,    63));
        foreach (tv[i]) begin
            apply(tv[i].coins, tv[i].sv, tv[i].price, tv[i].cn);
            check_vec($sformatf("table_%0d", i), dut_vec, tv[i].exp);
            if (tv[i].cnt >= 0)
                check_int($sformatf("table_%0d_count", i), int'(coin_count), tv[i].cnt);
        end

        // ---- cancel at full credit 63: 12 quarters, a dime, a nickel of change
        step("cancel63", C_N, 1'b0, 6'd0, 1'b1, O_REJ | O_BUSY);
        for (int i = 0; i < 12; i++) begin
            c = (i == 2) ? C_D : C_0;
            s = (i == 4);
            e = O_D25 | O_E25 | O_BUSY | ((i == 2) ? O_REJ : O_NONE) | ((i == 4) ? O_DEN : O_NONE);
            step($sformatf("chg63_q%0d", i), c, s, 6'd1, (i == 6), e);
        end
        step("chg63_dime",   C_0, 1'b0, 6'd0, 1'b0, O_D10 | O_E10 | O_BUSY);
        step("chg63_nickel", C_0, 1'b0, 6'd0, 1'b0, O_D5 | O_E5);
        step("chg63_idle",   C_0, 1'b0, 6'd0, 1'b0, O_NONE);
        check_int("chg63_count", int'(coin_count), 0);

        // ---- credit 10, price 7: deduct 5+2, dispense, change 2+1
        step("v_q1", C_Q, 1'b0, 6'd0, 1'b0, O_QUARTER);
        step("v_q2", C_Q, 1'b0, 6'd0, 1'b0, O_QUARTER);
        step("v_idle", C_0, 1'b0, 6'd0, 1'b0, O_NONE);
        bcnt = 0;
        step("v_sel", C_0, 1'b1, 6'd7, 1'b0, O_BUSY);           bcnt += int'(busy);
        step("v_d25", C_0, 1'b0, 6'd0, 1'b0, O_D25 | O_BUSY);   bcnt += int'(busy);
        step("v_d10", C_0, 1'b0, 6'd0, 1'b0, O_D10 | O_BUSY);   bcnt += int'(busy);
        step("v_disp", C_0, 1'b0, 6'd0, 1'b0, O_DISP | O_BUSY); bcnt += int'(busy);
        step("v_chg10", C_0, 1'b0, 6'd0, 1'b0, O_D10 | O_E10 | O_BUSY); bcnt += int'(busy);
        step("v_chg5", C_0, 1'b0, 6'd0, 1'b0, O_D5 | O_E5);     bcnt += int'(busy);
        check_int("vend_busy_cycles", bcnt, 5);
        step("v_after", C_0, 1'b0, 6'd0, 1'b0, O_NONE);
        check_int("vend_count", int'(coin_count), 0);

        // ---- credit 3: price above credit and zero are refused, exact price vends
        step("p_dime",   C_D, 1'b0, 6'd0, 1'b0, O_DIME);
        step("p_nickel", C_N, 1'b0, 6'd0, 1'b0, O_NICKEL);
        step("p_over",   C_0, 1'b1, 6'd4, 1'b0, O_DEN);
        step("p_zero",   C_0, 1'b1, 6'd0, 1'b0, O_DEN);
        check_int("p_count", int'(coin_count), 3);
        step("p_exact",  C_0, 1'b1, 6'd3, 1'b0, O_BUSY);
        step("p_d10",    C_0, 1'b0, 6'd0, 1'b0, O_D10 | O_BUSY);
        step("p_d5",     C_0, 1'b0, 6'd0, 1'b0, O_D5 | O_BUSY);
        step("p_disp",   C_0, 1'b0, 6'd0, 1'b0, O_DISP);
        step("p_idle",   C_0, 1'b0, 6'd0, 1'b0, O_NONE);
        check_int("p_final_count", int'(coin_count), 0);

        // ---- dollar then cancel: four quarters back, coin mid-payout rejected
        step("c_dollar", C_DL, 1'b0, 6'd0, 1'b0, O_DOLLAR);
        step("c_idle",   C_0,  1'b0, 6'd0, 1'b0, O_NONE);
        step("c_cancel", C_0,  1'b0, 6'd0, 1'b1, O_BUSY);
        step("c_q1", C_0, 1'b0, 6'd0, 1'b0, O_D25 | O_E25 | O_BUSY);
        step("c_q2", C_Q, 1'b0, 6'd0, 1'b0, O_D25 | O_E25 | O_BUSY | O_REJ);
        step("c_q3", C_0, 1'b0, 6'd0, 1'b0, O_D25 | O_E25 | O_BUSY);
        step("c_q4", C_0, 1'b0, 6'd0, 1'b0, O_D25 | O_E25);
        step("c_after", C_0, 1'b0, 6'd0, 1'b0, O_NONE);
        check_int("c_count", int'(coin_count), 0);

        // ---- simultaneous coins, then reset in the middle of a payout
        step("r_two_coins", C_N | C_DL, 1'b0, 6'd0, 1'b0, O_DOLLAR | O_REJ);
        step("r_idle",   C_0, 1'b0, 6'd0, 1'b0, O_NONE);
        step("r_cancel", C_0, 1'b0, 6'd0, 1'b1, O_BUSY);
        step("r_q1",     C_0, 1'b0, 6'd0, 1'b0, O_D25 | O_E25 | O_BUSY);
        reset = 1'b1;
        @(posedge clk);
        #1;
        check_vec("r_mid_reset", dut_vec, O_NONE);
        check_int("r_mid_reset_count", int'(coin_count), 0);
        @(negedge clk);
        reset = 1'b0;
        model_reset();
        for (int i = 0; i < 3; i++) step($sformatf("r_quiet_%0d", i), C_0, 1'b0, 6'd0, 1'b0, O_NONE);

        // ---- randomized traffic against the reference model
        for (int i = 0; i < 4000; i++) begin
            c[0] = ($urandom_range(0, 7) == 0);
            c[1] = ($urandom_range(0, 7) == 0);
            c[2] = ($urandom_range(0, 7) == 0);
            c[3] = ($urandom_range(0, 11) == 0);
            s    = ($urandom_range(0, 11) == 0);
            apply(c, s, ($urandom_range(0, 3) == 0) ? 6'($urandom_range(0, 63))
                                                    : 6'($urandom_range(0, 20)),
                  ($urandom_range(0, 39) == 0));
            check_vec($sformatf("rand_%0d", i), dut_vec, m_exp);
            if ((i % 8) == 7)
                check_int($sformatf("rand_%0d_count", i), int'(coin_count), m_credit_before);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
